// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the memory-stage SRAM controller: bus widths,
// the byte address that maps to SRAM word 0, and the controller state encoding.
package sram_mem_controller_pkg;

  localparam int REGISTER_LEN  = 32;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;

  localparam logic [REGISTER_LEN-1:0] SRAM_BASE = 32'd1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sram_mem_controller.sv
// Memory-stage controller: splits each 32-bit load/store into a low and a high
// 16-bit SRAM cycle followed by a settle wait, holding ready low meanwhile so
// the pipeline stays frozen until the access completes.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int unsigned               WAIT_CYCLES = 2,
  parameter logic [REGISTER_LEN-1:0]   SRAM_BASE   = sram_mem_controller_pkg::SRAM_BASE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic [REGISTER_LEN-1:0]   address,
  input  logic [REGISTER_LEN-1:0]   write_data,
  output logic [REGISTER_LEN-1:0]   read_data,
  output logic                      ready,
  output logic [SRAM_ADDR_LEN-1:0]  sram_addr,
  output logic [SRAM_DATA_LEN-1:0]  sram_dq_out,
  output logic                      sram_dq_oe,
  input  logic [SRAM_DATA_LEN-1:0]  sram_dq_in,
  output logic                      sram_we_n
);

  // Counter reload value when entering the settle wait (WAIT_CYCLES is 1..15).
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      is_write_q, is_write_d;
  logic [REGISTER_LEN-1:0]   read_data_q, read_data_d;

  logic                      request;
  logic [REGISTER_LEN-1:0]   word;
  logic [16:0]               word_idx;
  logic                      unused_addr_bits;

  // A simultaneous read and write request is treated as a write.
  assign request  = mem_read_in | mem_write_in;

  // Byte offset into SRAM; wraps mod 2^32 and aliases out-of-range addresses.
  assign word     = address - SRAM_BASE;
  assign word_idx = word[18:2];
  assign unused_addr_bits = ^{word[31:19], word[1:0]};

  assign read_data = read_data_q;

  // State register, wait counter, latched access kind and loaded word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
    end
  end

  // Next-state logic: IDLE -> LO -> HI -> WAIT (x WAIT_CYCLES) -> DONE -> IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (request) begin
          state_d    = ST_LO;
          is_write_d = mem_write_in;
        end
      end
      ST_LO: begin
        state_d = ST_HI;
        if (!is_write_q) read_data_d[15:0] = sram_dq_in;
      end
      ST_HI: begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_LOAD;
        if (!is_write_q) read_data_d[31:16] = sram_dq_in;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: SRAM bus controls per state plus the pipeline ready flag.
  // The write strobe and bus drive are suppressed while reset is asserted so a
  // reset landing mid-store does not complete the half-word being strobed.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    ready       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = !request;
      end
      ST_LO: begin
        sram_addr = {word_idx, 1'b0};
        if (is_write_q) begin
          sram_dq_out = write_data[15:0];
          sram_dq_oe  = rst;
          sram_we_n   = !rst;
        end
      end
      ST_HI: begin
        sram_addr = {word_idx, 1'b1};
        if (is_write_q) begin
          sram_dq_out = write_data[31:16];
          sram_dq_oe  = rst;
          sram_we_n   = !rst;
        end
      end
      ST_WAIT: begin
        sram_addr = {word_idx, 1'b1};
      end
      ST_DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed testbench for sram_mem_controller with a behavioural SRAM model.

// Behavioural 2^18 x 16 SRAM: asynchronous read, write on the clock edge while
// we_n is low, and a per-address write counter.
module sram_model (
  input  logic        clk,
  input  logic [17:0] addr,
  input  logic [15:0] dq_wr,
  input  logic        we_n,
  output logic [15:0] dq_rd
);
  logic [15:0] mem    [0:262143];
  int          wcount [0:262143];

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem[i]    = 16'h0000;
      wcount[i] = 0;
    end
  end

  assign dq_rd = mem[addr];

  always @(posedge clk) begin
    if (we_n == 1'b0) begin
      mem[addr]    <= dq_wr;
      wcount[addr] <= wcount[addr] + 1;
    end
  end
endmodule

module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        rd_w1 = 1'b0, rd_w15 = 1'b0;
  logic        wr_off = 1'b0;

  // default instance
  logic [31:0] rdata;
  logic        ready, s_oe, s_we_n;
  logic [17:0] s_addr;
  logic [15:0] s_dq_out, s_dq_in;
  // WAIT_CYCLES = 1 instance
  logic [31:0] rdata_w1;
  logic        ready_w1, oe_w1, we_n_w1;
  logic [17:0] addr_w1;
  logic [15:0] dq_out_w1, dq_in_w1;
  // WAIT_CYCLES = 15 instance
  logic [31:0] rdata_w15;
  logic        ready_w15, oe_w15, we_n_w15;
  logic [17:0] addr_w15;
  logic [15:0] dq_out_w15, dq_in_w15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk(clk), .rst(rst), .mem_read_in(rd), .mem_write_in(wr),
    .address(addr), .write_data(wdata), .read_data(rdata), .ready(ready),
    .sram_addr(s_addr), .sram_dq_out(s_dq_out), .sram_dq_oe(s_oe),
    .sram_dq_in(s_dq_in), .sram_we_n(s_we_n)
  );
  sram_model u_mem (.clk(clk), .addr(s_addr), .dq_wr(s_dq_out), .we_n(s_we_n), .dq_rd(s_dq_in));

  sram_mem_controller #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .mem_read_in(rd_w1), .mem_write_in(wr_off),
    .address(addr), .write_data(wdata), .read_data(rdata_w1), .ready(ready_w1),
    .sram_addr(addr_w1), .sram_dq_out(dq_out_w1), .sram_dq_oe(oe_w1),
    .sram_dq_in(dq_in_w1), .sram_we_n(we_n_w1)
  );
  sram_model u_mem_w1 (.clk(clk), .addr(addr_w1), .dq_wr(dq_out_w1), .we_n(we_n_w1), .dq_rd(dq_in_w1));

  sram_mem_controller #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .mem_read_in(rd_w15), .mem_write_in(wr_off),
    .address(addr), .write_data(wdata), .read_data(rdata_w15), .ready(ready_w15),
    .sram_addr(addr_w15), .sram_dq_out(dq_out_w15), .sram_dq_oe(oe_w15),
    .sram_dq_in(dq_in_w15), .sram_we_n(we_n_w15)
  );
  sram_model u_mem_w15 (.clk(clk), .addr(addr_w15), .dq_wr(dq_out_w15), .we_n(we_n_w15), .dq_rd(dq_in_w15));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request on the default instance in the current (IDLE) cycle and
  // advances until ready rises (DONE). Requests are left asserted.
  task automatic run_access(input logic is_rd, input logic is_wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output int low, output logic we_seen);
    rd = is_rd; wr = is_wr; addr = a; wdata = d;
    low = 0;
    we_seen = 1'b0;
    #0;
    while (ready !== 1'b1 && low < 50) begin
      if (s_we_n === 1'b0) we_seen = 1'b1;
      low++;
      step();
    end
    if (s_we_n === 1'b0) we_seen = 1'b1;
  endtask

  task automatic release_req();
    rd = 1'b0; wr = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL reset_ready got %0b want 1", ready); end
    checks++; if (s_we_n !== 1'b1)    begin errors++; $display("FAIL reset_we_n got %0b want 1", s_we_n); end
    checks++; if (s_oe !== 1'b0)      begin errors++; $display("FAIL reset_oe got %0b want 0", s_oe); end
    checks++; if (s_addr !== 18'd0)   begin errors++; $display("FAIL reset_addr got %h want 0", s_addr); end
    checks++; if (s_dq_out !== 16'd0) begin errors++; $display("FAIL reset_dq_out got %h want 0", s_dq_out); end
    checks++; if (rdata !== 32'd0)    begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    rst = 1'b1;
    step();
    $display("reset: ready=%0b we_n=%0b rdata=%h", ready, s_we_n, rdata);
  endtask

  task automatic test_store();
    int low; logic we_seen;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, low, we_seen);
    checks++; if (low !== 5) begin errors++; $display("FAIL store_ready_low got %0d want 5", low); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL store_done_ready got %0b want 1", ready); end
    release_req();
    checks++; if (u_mem.mem[0] !== 16'hBEEF) begin errors++; $display("FAIL store_lo got %h want beef", u_mem.mem[0]); end
    checks++; if (u_mem.mem[1] !== 16'hDEAD) begin errors++; $display("FAIL store_hi got %h want dead", u_mem.mem[1]); end
    $display("store @1024 data=deadbeef: low=%0d sram0=%h sram1=%h", low, u_mem.mem[0], u_mem.mem[1]);
  endtask

  task automatic test_load();
    int low; logic we_seen;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, low, we_seen);
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", rdata); end
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL load_we_n saw a write strobe during load"); end
    checks++; if (low !== 5) begin errors++; $display("FAIL load_ready_low got %0d want 5", low); end
    release_req();
    $display("load @1024: low=%0d rdata=%h", low, rdata);
  endtask

  task automatic test_store_load_lowbits();
    int low; logic we_seen;
    run_access(1'b0, 1'b1, 32'd1028, 32'h12345678, low, we_seen);
    release_req();
    checks++; if (u_mem.mem[2] !== 16'h5678) begin errors++; $display("FAIL lowbits_sram2 got %h want 5678", u_mem.mem[2]); end
    checks++; if (u_mem.mem[3] !== 16'h1234) begin errors++; $display("FAIL lowbits_sram3 got %h want 1234", u_mem.mem[3]); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lowbits_hold got %h want deadbeef", rdata); end
    run_access(1'b1, 1'b0, 32'd1031, 32'h0, low, we_seen);
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL lowbits_load got %h want 12345678", rdata); end
    release_req();
    $display("store @1028 / load @1031: rdata=%h", rdata);
  endtask

  task automatic test_both_high();
    int low; logic we_seen;
    run_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, low, we_seen);
    checks++; if (we_seen !== 1'b1) begin errors++; $display("FAIL both_we no write strobe seen"); end
    release_req();
    checks++; if (u_mem.mem[4] !== 16'h5A5A) begin errors++; $display("FAIL both_sram4 got %h want 5a5a", u_mem.mem[4]); end
    checks++; if (u_mem.mem[5] !== 16'hA5A5) begin errors++; $display("FAIL both_sram5 got %h want a5a5", u_mem.mem[5]); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL both_rdata got %h want 12345678", rdata); end
    $display("both high @1032: sram4=%h sram5=%h rdata=%h", u_mem.mem[4], u_mem.mem[5], rdata);
  endtask

  task automatic test_reset_mid_store();
    wr = 1'b1; addr = 32'd1040; wdata = 32'hCAFEF00D;
    step();            // LO
    step();            // HI
    rst = 1'b0; wr = 1'b0;
    step();
    checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL midrst_ready got %0b want 1", ready); end
    checks++; if (s_we_n !== 1'b1)    begin errors++; $display("FAIL midrst_we_n got %0b want 1", s_we_n); end
    checks++; if (s_oe !== 1'b0)      begin errors++; $display("FAIL midrst_oe got %0b want 0", s_oe); end
    checks++; if (s_addr !== 18'd0)   begin errors++; $display("FAIL midrst_addr got %h want 0", s_addr); end
    checks++; if (rdata !== 32'd0)    begin errors++; $display("FAIL midrst_rdata got %h want 0", rdata); end
    checks++; if (u_mem.mem[8] !== 16'hF00D) begin errors++; $display("FAIL midrst_lo got %h want f00d", u_mem.mem[8]); end
    checks++; if (u_mem.wcount[9] !== 0) begin errors++; $display("FAIL midrst_hi_count got %0d want 0", u_mem.wcount[9]); end
    rst = 1'b1;
    step();
    checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL midrst_idle_ready got %0b want 1", ready); end
    $display("reset in HI: sram8=%h writes9=%0d rdata=%h", u_mem.mem[8], u_mem.wcount[9], rdata);
  endtask

  task automatic test_back_to_back_wait();
    int low1, low2;
    addr = 32'd1024;
    // WAIT_CYCLES = 1: two loads, request held through DONE
    rd_w1 = 1'b1;
    low1 = 0; #0;
    while (ready_w1 !== 1'b1 && low1 < 50) begin low1++; step(); end
    step();
    low2 = 0;
    while (ready_w1 !== 1'b1 && low2 < 50) begin low2++; step(); end
    rd_w1 = 1'b0;
    step();
    checks++; if (low1 !== 4) begin errors++; $display("FAIL w1_first got %0d want 4", low1); end
    checks++; if (low2 !== 4) begin errors++; $display("FAIL w1_second got %0d want 4", low2); end
    $display("WAIT_CYCLES=1 back-to-back loads: low=%0d,%0d", low1, low2);
    // WAIT_CYCLES = 15
    rd_w15 = 1'b1;
    low1 = 0; #0;
    while (ready_w15 !== 1'b1 && low1 < 50) begin low1++; step(); end
    step();
    low2 = 0;
    while (ready_w15 !== 1'b1 && low2 < 50) begin low2++; step(); end
    rd_w15 = 1'b0;
    step();
    checks++; if (low1 !== 18) begin errors++; $display("FAIL w15_first got %0d want 18", low1); end
    checks++; if (low2 !== 18) begin errors++; $display("FAIL w15_second got %0d want 18", low2); end
    $display("WAIT_CYCLES=15 back-to-back loads: low=%0d,%0d", low1, low2);
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_store_load_lowbits();
    test_both_high();
    test_reset_mid_store();
    test_back_to_back_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
